// File: rtl/nes_cpu_pkg.sv
// nes_cpu_pkg
// Shared types and constants for the CPU front end.
//   MEM_ADDR_SIZE / ADDR_W : byte address width of the CPU memory
//   RESET_VEC_ADDR         : address of the 6502 reset vector low byte
//   fetch_state_e          : instruction fetch FSM states
//   instr_len_t            : instruction length in bytes (1..3)
package nes_cpu_pkg;

  localparam int MEM_ADDR_SIZE = 16;
  localparam int ADDR_W        = MEM_ADDR_SIZE;

  // Narrower memories see the vector address truncated to their width.
  localparam logic [15:0]       RESET_VEC_FULL = 16'hFFFC;
  localparam logic [ADDR_W-1:0] RESET_VEC_ADDR = RESET_VEC_FULL[ADDR_W-1:0];

  typedef enum logic {
    VEC,
    FETCH
  } fetch_state_e;

  typedef logic [1:0] instr_len_t;

endpackage

// File: rtl/opcode_len_dec.sv
// opcode_len_dec
// Purely combinational 6502 opcode length decoder.
//   i_opcode : opcode byte
//   o_len    : instruction length in bytes (1..3)
module opcode_len_dec
  import nes_cpu_pkg::*;
(
  input  logic [7:0] i_opcode,
  output instr_len_t o_len
);

  logic [1:0] w_cc;
  logic [2:0] w_bbb;

  assign w_cc  = i_opcode[1:0];
  assign w_bbb = i_opcode[4:2];

  // JSR and the three implied-mode control opcodes (BRK/RTI/RTS) break the
  // regular cc/bbb addressing-mode pattern, so they are caught first.
  always_comb begin
    o_len = 2'd1;
    if (i_opcode == 8'h20) begin
      o_len = 2'd3;
    end else if (i_opcode == 8'h00 || i_opcode == 8'h40 || i_opcode == 8'h60) begin
      o_len = 2'd1;
    end else begin
      case (w_cc)
        2'b11: o_len = 2'd1;
        2'b01: begin
          if (w_bbb == 3'b011 || w_bbb == 3'b110 || w_bbb == 3'b111) begin
            o_len = 2'd3;
          end else begin
            o_len = 2'd2;
          end
        end
        default: begin
          case (w_bbb)
            3'b000:  o_len = 2'd2;
            3'b001:  o_len = 2'd2;
            3'b010:  o_len = 2'd1;
            3'b011:  o_len = 2'd3;
            // bbb=100 is a relative branch for cc=00 but implied/illegal for cc=10
            3'b100:  o_len = (w_cc == 2'b00) ? 2'd2 : 2'd1;
            3'b101:  o_len = 2'd2;
            3'b110:  o_len = 2'd1;
            default: o_len = 2'd3;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Read-side instruction fetcher: loads the start PC from the reset vector,
// then reads 24-bit windows at the PC and hands whole instructions to decode.
//   clk_i, rstn_i  : clock, asynchronous active-low reset
//   mem_addr_o     : memory read address (combinational)
//   mem_data_i     : {addr+2, addr+1, addr+0} returned in the same cycle
//   instr_valid_o  : instruction slot full
//   instr_ready_i  : decode accepts the slot
//   instr_o        : raw instruction bytes, [7:0] = opcode
//   instr_len_o    : instruction length 1..3
//   instr_pc_o     : address of the opcode
//   redirect_i     : load redirect_pc_i as the new PC (highest priority)
//   redirect_pc_i  : new PC
module instr_fetch
  import nes_cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [23:0]       mem_data_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [23:0]       instr_o,
  output logic [1:0]        instr_len_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  fetch_state_e      r_state, w_state;
  logic [ADDR_W-1:0] r_pc, w_pc;
  logic              r_valid, w_valid;
  logic [23:0]       r_instr, w_instr;
  instr_len_t        r_len, w_len;
  logic [ADDR_W-1:0] r_instr_pc, w_instr_pc;
  instr_len_t        w_dec_len;
  logic              w_slot_free;

  opcode_len_dec u_len_dec (
    .i_opcode (mem_data_i[7:0]),
    .o_len    (w_dec_len)
  );

  assign mem_addr_o    = (r_state == VEC) ? RESET_VEC_ADDR : r_pc;
  assign w_slot_free   = !r_valid || instr_ready_i;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_len_o   = r_len;
  assign instr_pc_o    = r_instr_pc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= VEC;
      r_pc       <= '0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_len      <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_valid    <= w_valid;
      r_instr    <= w_instr;
      r_len      <= w_len;
      r_instr_pc <= w_instr_pc;
    end
  end

  // Redirect overrides everything: the window read this cycle belongs to the
  // old PC and is dropped. The payload registers are left alone on redirect
  // since valid is cleared anyway.
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_valid    = r_valid;
    w_instr    = r_instr;
    w_len      = r_len;
    w_instr_pc = r_instr_pc;
    if (redirect_i) begin
      w_state = FETCH;
      w_pc    = redirect_pc_i;
      w_valid = 1'b0;
    end else begin
      case (r_state)
        VEC: begin
          w_pc    = mem_data_i[ADDR_W-1:0];
          w_state = FETCH;
        end
        default: begin
          if (w_slot_free) begin
            w_instr    = mem_data_i;
            w_len      = w_dec_len;
            w_instr_pc = r_pc;
            w_valid    = 1'b1;
            w_pc       = r_pc + ADDR_W'(w_dec_len);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Self-checking bench for instr_fetch: a byte-array memory model feeds the
// DUT, and a reference walk over that memory (using the opcode length rules)
// predicts every instruction the fetcher should present.
module tb_instr_fetch;
  import nes_cpu_pkg::*;

  logic              clk_i;
  logic              rstn_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [23:0]       mem_data_i;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic [23:0]       instr_o;
  logic [1:0]        instr_len_o;
  logic [ADDR_W-1:0] instr_pc_o;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;

  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .mem_addr_o    (mem_addr_o),
    .mem_data_i    (mem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_len_o   (instr_len_o),
    .instr_pc_o    (instr_pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Little-endian 24-bit window, wrapping around the 64 KiB space.
  logic [15:0] a0, a1, a2;
  assign a0 = mem_addr_o;
  assign a1 = a0 + 16'd1;
  assign a2 = a0 + 16'd2;
  assign mem_data_i = {mem[a2], mem[a1], mem[a0]};

  // Reference opcode length, straight from the 6502 addressing-mode table.
  function automatic int ref_len(input logic [7:0] op);
    int cc;
    int bbb;
    cc  = int'(op) % 4;
    bbb = (int'(op) / 4) % 8;
    if (op == 8'h20) return 3;
    if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 1;
    if (cc == 3) return 1;
    if (cc == 1) return (bbb == 3 || bbb == 6 || bbb == 7) ? 3 : 2;
    case (bbb)
      2, 6:    return 1;
      3, 7:    return 3;
      4:       return (cc == 0) ? 2 : 1;
      default: return 2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    #2;
    checks++;
    if (instr_valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid got=%b exp=0", instr_valid_o);
    end
    checks++;
    if (instr_o !== 24'h0 || instr_len_o !== 2'd0 || instr_pc_o !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_payload got=%h/%0d/%h exp=000000/0/0000", instr_o, instr_len_o, instr_pc_o);
    end
    checks++;
    if (mem_addr_o !== 16'hFFFC) begin
      errors++; $display("[TB] FAIL reset_addr got=%h exp=fffc", mem_addr_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    checks++;
    if (instr_valid_o !== 1'b0 || mem_addr_o !== 16'h8000) begin
      errors++; $display("[TB] FAIL vector_load valid=%b addr=%h exp valid=0 addr=8000", instr_valid_o, mem_addr_o);
    end
    tick();
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h8000 || instr_len_o !== 2'd2 || instr_o[15:0] !== 16'h05A9) begin
      errors++;
      $display("[TB] FAIL first_instr valid=%b pc=%h len=%0d instr=%h exp 1/8000/2/..05a9",
               instr_valid_o, instr_pc_o, instr_len_o, instr_o);
    end
  endtask

  task automatic test_length_seq();
    instr_ready_i = 1'b1;
    tick();
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h8002 || instr_len_o !== 2'd3 || instr_o !== 24'h80104C) begin
      errors++;
      $display("[TB] FAIL jmp_instr valid=%b pc=%h len=%0d instr=%h exp 1/8002/3/80104c",
               instr_valid_o, instr_pc_o, instr_len_o, instr_o);
    end
    tick();
    instr_ready_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h8005 || instr_len_o !== 2'd1 || instr_o[7:0] !== 8'hEA) begin
      errors++;
      $display("[TB] FAIL nop_instr valid=%b pc=%h len=%0d instr=%h exp 1/8005/1/....ea",
               instr_valid_o, instr_pc_o, instr_len_o, instr_o);
    end
    checks++;
    if (mem_addr_o !== 16'h8006) begin
      errors++; $display("[TB] FAIL pc_after_seq got=%h exp=8006", mem_addr_o);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] hold_instr;
    logic [1:0]  hold_len;
    logic [15:0] hold_pc;
    logic [15:0] next_pc;
    hold_instr = instr_o;
    hold_len   = instr_len_o;
    hold_pc    = instr_pc_o;
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid_o !== 1'b1 || instr_o !== hold_instr || instr_len_o !== hold_len ||
          instr_pc_o !== hold_pc || mem_addr_o !== 16'h8006) begin
        errors++;
        $display("[TB] FAIL stall_%0d valid=%b instr=%h len=%0d pc=%h addr=%h exp 1/%h/%0d/%h/8006",
                 i, instr_valid_o, instr_o, instr_len_o, instr_pc_o, mem_addr_o, hold_instr, hold_len, hold_pc);
      end
    end
    instr_ready_i = 1'b1;
    tick();
    next_pc = 16'h8006;
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== next_pc || int'(instr_len_o) != ref_len(mem[next_pc]) ||
        instr_o !== {mem[next_pc+16'd2], mem[next_pc+16'd1], mem[next_pc]}) begin
      errors++;
      $display("[TB] FAIL after_stall valid=%b pc=%h len=%0d instr=%h exp pc=%h len=%0d",
               instr_valid_o, instr_pc_o, instr_len_o, instr_o, next_pc, ref_len(mem[next_pc]));
    end
    tick();
    instr_ready_i = 1'b0;
    next_pc = next_pc + 16'(ref_len(mem[next_pc]));
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== next_pc || int'(instr_len_o) != ref_len(mem[next_pc])) begin
      errors++;
      $display("[TB] FAIL back_to_back valid=%b pc=%h len=%0d exp pc=%h len=%0d",
               instr_valid_o, instr_pc_o, instr_len_o, next_pc, ref_len(mem[next_pc]));
    end
  endtask

  task automatic test_redirect_stalled();
    instr_ready_i = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 16'h1234;
    tick();
    redirect_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0 || mem_addr_o !== 16'h1234) begin
      errors++; $display("[TB] FAIL redirect_drop valid=%b addr=%h exp 0/1234", instr_valid_o, mem_addr_o);
    end
    tick();
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h1234 || int'(instr_len_o) != ref_len(mem[16'h1234])) begin
      errors++;
      $display("[TB] FAIL redirect_target valid=%b pc=%h len=%0d exp 1/1234/%0d",
               instr_valid_o, instr_pc_o, instr_len_o, ref_len(mem[16'h1234]));
    end
  endtask

  task automatic test_wrap();
    instr_ready_i = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 16'hFFFE;
    tick();
    redirect_i = 1'b0;
    tick();
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'hFFFE || instr_len_o !== 2'd3 || instr_o !== 24'h12344C) begin
      errors++;
      $display("[TB] FAIL wrap_instr valid=%b pc=%h len=%0d instr=%h exp 1/fffe/3/12344c",
               instr_valid_o, instr_pc_o, instr_len_o, instr_o);
    end
    checks++;
    if (mem_addr_o !== 16'h0001) begin
      errors++; $display("[TB] FAIL wrap_pc got=%h exp=0001", mem_addr_o);
    end
  endtask

  task automatic test_async_reset();
    instr_ready_i = 1'b1;
    tick();
    #2;
    rstn_i = 1'b0;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0 || mem_addr_o !== 16'hFFFC || instr_pc_o !== 16'h0) begin
      errors++;
      $display("[TB] FAIL async_reset valid=%b addr=%h pc=%h exp 0/fffc/0000", instr_valid_o, mem_addr_o, instr_pc_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    checks++;
    if (instr_valid_o !== 1'b0 || mem_addr_o !== 16'h8000) begin
      errors++; $display("[TB] FAIL revector valid=%b addr=%h exp 0/8000", instr_valid_o, mem_addr_o);
    end
    tick();
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h8000) begin
      errors++; $display("[TB] FAIL restart valid=%b pc=%h exp 1/8000", instr_valid_o, instr_pc_o);
    end
  endtask

  // Random ready/redirect traffic over random code. The model is simply "the
  // instruction stream starting at the last redirect target": each accepted
  // instruction advances the expected PC by its reference length.
  task automatic test_random_stream();
    logic [15:0] exp_pc;
    logic [15:0] ba;
    logic        prev_redir;
    logic        rdy;
    logic        redir;
    logic [15:0] target;
    int          elen;
    exp_pc        = 16'h0200 + 16'($urandom_range(0, 16'h2000));
    redirect_i    = 1'b1;
    redirect_pc_i = exp_pc;
    instr_ready_i = 1'b0;
    tick();
    redirect_i = 1'b0;
    prev_redir = 1'b1;
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (instr_valid_o !== !prev_redir) begin
        errors++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", i, instr_valid_o, !prev_redir);
      end
      elen = ref_len(mem[exp_pc]);
      if (instr_valid_o === 1'b1) begin
        checks++;
        if (instr_pc_o !== exp_pc || int'(instr_len_o) != elen) begin
          errors++;
          $display("[TB] FAIL rnd_slot cyc=%0d pc=%h len=%0d exp pc=%h len=%0d", i, instr_pc_o, instr_len_o, exp_pc, elen);
        end
        for (int k = 0; k < elen; k++) begin
          ba = exp_pc + 16'(k);
          checks++;
          if (instr_o[8*k +: 8] !== mem[ba]) begin
            errors++; $display("[TB] FAIL rnd_byte%0d cyc=%0d got=%h exp=%h", k, i, instr_o[8*k +: 8], mem[ba]);
          end
        end
      end
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      target = 16'h0200 + 16'($urandom_range(0, 16'h2000));
      instr_ready_i = rdy;
      redirect_i    = redir;
      redirect_pc_i = target;
      if (instr_valid_o === 1'b1 && rdy) exp_pc = exp_pc + 16'(elen);
      if (redir) exp_pc = target;
      prev_redir = redir;
      tick();
    end
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  initial begin
    rstn_i        = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h05;
    mem[16'h8002] = 8'h4C; mem[16'h8003] = 8'h10; mem[16'h8004] = 8'h80;
    mem[16'h8005] = 8'hEA;
    mem[16'h8006] = 8'hAD; mem[16'h8007] = 8'h00; mem[16'h8008] = 8'h02;
    mem[16'h8009] = 8'hE8;
    mem[16'h1234] = 8'hA2;
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;

    test_reset();
    test_length_seq();
    test_backpressure();
    test_redirect_stalled();
    test_wrap();
    test_async_reset();
    test_random_stream();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Read-side initiator for the CPU memory (mem_t).
- Drives the memory byte address and takes the 24-bit little-endian window {addr+2, addr+1, addr+0} that the memory returns combinationally in the same cycle.
- Loads the start PC from the 6502 reset vector, decodes each opcode's length (1/2/3 bytes), and presents whole instructions to decode over a valid/ready handshake.
- Supports PC redirect for branches and jumps.

Parameters:
- ADDR_W, MEM_ADDR_SIZE (package): byte address width, same as the memory.
- RESET_VEC_ADDR, 16'hFFFC truncated to ADDR_W: address of the reset vector low byte.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- mem_addr_o  out  ADDR_W  memory read address
- mem_data_i  in  24  memory read data, same cycle as mem_addr_o; [7:0]=byte at addr
- instr_valid_o  out  1  instruction slot full
- instr_ready_i  in  1  decode accepts the slot
- instr_o  out  24  raw instruction bytes; [7:0]=opcode; bytes beyond instr_len_o are don't-care
- instr_len_o  out  2  instruction length, 1..3
- instr_pc_o  out  ADDR_W  address of the opcode
- redirect_i  in  1  load a new PC
- redirect_pc_i  in  ADDR_W  new PC

Behaviour:
- Reset (async assert, sync release): state=VEC, pc_q=0, instr_valid_o=0, instr_o=0, instr_len_o=0, instr_pc_o=0. mem_addr_o is the combinational mux output, so it equals RESET_VEC_ADDR during reset.
- States: VEC, FETCH.
- VEC:
  - mem_addr_o=RESET_VEC_ADDR.
  - On the first clock edge after reset release: pc_q <= mem_data_i[15:0] truncated to ADDR_W; state -> FETCH.
  - Valid stays 0 throughout.
- FETCH:
  - mem_addr_o=pc_q.
  - slot_free = !instr_valid_o || instr_ready_i.
  - If slot_free: instr_o<=mem_data_i, instr_len_o<=len(mem_data_i[7:0]), instr_pc_o<=pc_q, instr_valid_o<=1, pc_q<=pc_q+len, modulo 2^ADDR_W (wraps at top).
  - Otherwise all registers hold.
- Handshake:
  - While instr_valid_o=1 && !instr_ready_i, the payload is stable.
  - Transfer occurs on valid&&ready.
  - Sustained throughput is 1 instruction/cycle.
  - Latency from a new PC to valid is 1 cycle.
- Redirect (highest priority, any state):
  - Next edge: pc_q<=redirect_pc_i, instr_valid_o<=0, state->FETCH.
  - The data sampled that cycle is discarded.
  - A slot handshaken in the same cycle counts as consumed.
  - Redirect during VEC skips the vector load.
- Length decode, with cc=op[1:0], bbb=op[4:2]:
  - op 0x20 (JSR) -> 3.
  - op 0x00, 0x40, 0x60 -> 1.
  - cc=11 -> 1.
  - cc=01: bbb 011, 110, 111 -> 3; otherwise 2.
  - cc=00/10:
    - bbb 000 -> 2
    - bbb 001 -> 2
    - bbb 010 -> 1
    - bbb 011 -> 3
    - bbb 100 -> 2 if cc=00, else 1
    - bbb 101 -> 2
    - bbb 110 -> 1
    - bbb 111 -> 3
- Async reset mid-transfer: valid drops immediately; after release the vector is fetched again.
- No memory writes are issued; the block never drives memory data.

Decomposition:
- Package nes_cpu_pkg gets:
  - fetch_state_e {VEC, FETCH}
  - RESET_VEC_ADDR
  - typedef instr_len_t logic [1:0]
- Sub-module opcode_len_dec: purely combinational, opcode[7:0] -> instr_len_t. It is reused later by the decoder and tested standalone.

Test Plan:
- Reset vector: memory[FFFC]=0x00, [FFFD]=0x80 (ADDR_W=16), release reset -> 1st edge pc=0x8000, 2nd edge valid=1, instr_pc_o=0x8000.
- Length sequence: bytes at 0x8000 = A9 05 4C 10 80 EA with ready=1 -> three transfers:
  - len 2 at 0x8000
  - len 3 at 0x8002 (instr_o=0x80104C)
  - len 1 at 0x8005
  - Then pc=0x8006.
- Backpressure: ready=0 for 3 cycles while valid -> instr_o, instr_pc_o, instr_len_o and pc unchanged; ready=1 -> transfer, next instruction follows the next cycle.
- Redirect while stalled (valid=1, ready=0): redirect_pc_i=0x1234 -> next cycle valid=0; the cycle after, valid=1 with instr_pc_o=0x1234.
- Wrap: pc=0xFFFE, opcode 0x4C -> len 3, pc becomes 0x0001.
- Async reset asserted mid-stream (between clock edges) -> instr_valid_o=0 immediately; after release, the vector is re-read and fetch restarts at the vector target.
